camera_rgb_sampler: RTL

Upstream pixel stage for the camera PIO inputs of the Qsys system. It consumes the camera's registered pixel stream and averages the R, G and B components over a fixed rectangular window each frame. At end of frame it latches three 8-bit averages, which drive `camera_red_in`, `camera_green_in` and `camera_blue_in`, so the CPU always reads a value from one consistent frame.

---
 rtl/camera_pkg.sv | 19 +
 rtl/camera_chan_accum.sv | 44 ++++
 rtl/camera_rgb_sampler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the camera RGB window sampler.
package camera_pkg;

    // Width of each averaged component handed to the PIO.
    localparam int OUT_W = 8;

    // Per-frame sampler states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } camState_e;

    // Accumulator width that holds a full window of maximum-valued pixels.
    function automatic int accWidth(input int pixW, input int log2W, input int log2H);
        return pixW + log2W + log2H;
    endfunction

endpackage

// File: rtl/camera_chan_accum.sv
// camera_chan_accum: one colour channel's window accumulator. It keeps a
// running sum of enabled pixels and exposes the top OUT_W bits of the sum,
// which equals the window average once a full window has been summed.
module camera_chan_accum
    import camera_pkg::*;
#(
    parameter int PIX_W = 10,
    parameter int SUM_W = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [OUT_W-1:0] avg_o
);

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;

    // Clear wins over accumulate so a new frame always starts from zero.
    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (enable_i) begin
            sum_d = sum_q + SUM_W'(pix_i);
        end
    end

    // Running-sum register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
    assign avg_o = sum_q[SUM_W-1 -: OUT_W];

endmodule

// File: rtl/camera_rgb_sampler.sv
// camera_rgb_sampler: averages R/G/B over a fixed rectangular window of each
// camera frame and latches the three 8-bit averages at end of frame.
// Optional macro CAMERA_RGB_SAMPLER_FRAMECNT_EN adds a 16-bit frame_count
// output that counts every completed (good or short) frame.
// PIX_W must be at least 8.
module camera_rgb_sampler
    import camera_pkg::*;
#(
    parameter int PIX_W      = 10,
    parameter int WIN_X0     = 0,
    parameter int WIN_Y0     = 0,
    parameter int WIN_LOG2_W = 4,
    parameter int WIN_LOG2_H = 4
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             frame_valid,
    input  logic             line_valid,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    output logic [OUT_W-1:0] red_out,
    output logic [OUT_W-1:0] green_out,
    output logic [OUT_W-1:0] blue_out,
    output logic             result_valid,
    output logic             short_frame
`ifdef CAMERA_RGB_SAMPLER_FRAMECNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int ACC_W = accWidth(PIX_W, WIN_LOG2_W, WIN_LOG2_H);
    localparam int N_W   = WIN_LOG2_W + WIN_LOG2_H + 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W:0] X_LO = (CNT_W+1)'(WIN_X0);
    localparam logic [CNT_W:0] X_HI = (CNT_W+1)'(WIN_X0 + (1 << WIN_LOG2_W));
    localparam logic [CNT_W:0] Y_LO = (CNT_W+1)'(WIN_Y0);
    localparam logic [CNT_W:0] Y_HI = (CNT_W+1)'(WIN_Y0 + (1 << WIN_LOG2_H));
    localparam logic [N_W-1:0] N_FULL = {1'b1, {(N_W-1){1'b0}}};

    // Stage R registers and their delayed copies for edge detection.
    logic             fvR_q, fvDly_q;
    logic             lvR_q, lvDly_q;
    logic             pvR_q;
    logic [PIX_W-1:0] rR_q, gR_q, bR_q;

    logic fvRise, fvFall, lvFall;

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             xInWin, yInWin;

    logic [N_W-1:0] n_q, n_d;
    logic           nFull;

    camState_e state_q, state_d;
    logic      clearAcc, accEn, latchOut;

    logic [OUT_W-1:0] avgR, avgG, avgB;
    logic [ACC_W-1:0] unusedSumR, unusedSumG, unusedSumB;

    logic [OUT_W-1:0] red_q, red_d;
    logic [OUT_W-1:0] green_q, green_d;
    logic [OUT_W-1:0] blue_q, blue_d;
    logic             resultValid_q, resultValid_d;
    logic             shortFrame_q, shortFrame_d;

    // Register every input once; the frame_valid pair resets high so a frame
    // already in progress at reset release never looks like a rising edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fvR_q   <= 1'b1;
            fvDly_q <= 1'b1;
            lvR_q   <= 1'b0;
            lvDly_q <= 1'b0;
            pvR_q   <= 1'b0;
            rR_q    <= '0;
            gR_q    <= '0;
            bR_q    <= '0;
        end else begin
            fvR_q   <= frame_valid;
            fvDly_q <= fvR_q;
            lvR_q   <= line_valid;
            lvDly_q <= lvR_q;
            pvR_q   <= pix_valid;
            rR_q    <= pix_r;
            gR_q    <= pix_g;
            bR_q    <= pix_b;
        end
    end

    assign fvRise = fvR_q & ~fvDly_q;
    assign fvFall = ~fvR_q & fvDly_q;
    assign lvFall = ~lvR_q & lvDly_q;

    // Column/row counters; they saturate so a very long line or frame can
    // never wrap back into the window.
    always_comb begin
        x_d = x_q;
        if (lvFall) begin
            x_d = '0;
        end else if (pvR_q && (x_q != '1)) begin
            x_d = x_q + 1'b1;
        end
        y_d = y_q;
        if (fvRise) begin
            y_d = '0;
        end else if (lvFall && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Position counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign xInWin = ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI);
    assign yInWin = ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; DONE follows a coincident frame start straight into
    // ACTIVE so back-to-back frames are not dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fvRise) state_d = ACTIVE;
            ACTIVE:  if (fvFall) state_d = DONE;
            DONE:    state_d = fvRise ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; accumulators clear in every non-ACTIVE cycle, and DONE
    // latches the results on the same edge that clears them.
    always_comb begin
        clearAcc = 1'b1;
        accEn    = 1'b0;
        latchOut = 1'b0;
        unique case (state_q)
            ACTIVE: begin
                clearAcc = 1'b0;
                accEn    = pvR_q & xInWin & yInWin;
            end
            DONE:    latchOut = 1'b1;
            default: ;
        endcase
    end

    // Count of in-window pixels summed this frame.
    always_comb begin
        n_d = n_q;
        if (clearAcc) begin
            n_d = '0;
        end else if (accEn && (n_q != '1)) begin
            n_d = n_q + 1'b1;
        end
    end

    // Pixel count register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end

    assign nFull = (n_q == N_FULL);

    // The running sums are only observed through the scaled averages here.
    camera_chan_accum #(.PIX_W(PIX_W), .SUM_W(ACC_W)) uAccR (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .clear_i (clearAcc),
        .enable_i(accEn),
        .pix_i   (rR_q),
        .sum_o   (unusedSumR),
        .avg_o   (avgR)
    );

    camera_chan_accum #(.PIX_W(PIX_W), .SUM_W(ACC_W)) uAccG (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .clear_i (clearAcc),
        .enable_i(accEn),
        .pix_i   (gR_q),
        .sum_o   (unusedSumG),
        .avg_o   (avgG)
    );

    camera_chan_accum #(.PIX_W(PIX_W), .SUM_W(ACC_W)) uAccB (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .clear_i (clearAcc),
        .enable_i(accEn),
        .pix_i   (bR_q),
        .sum_o   (unusedSumB),
        .avg_o   (avgB)
    );

    // Result latch: a complete window updates the averages, an incomplete one
    // keeps the previous frame's values and only raises short_frame.
    always_comb begin
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        resultValid_d = 1'b0;
        shortFrame_d  = 1'b0;
        if (latchOut) begin
            if (nFull) begin
                red_d         = avgR;
                green_d       = avgG;
                blue_d        = avgB;
                resultValid_d = 1'b1;
            end else begin
                shortFrame_d  = 1'b1;
            end
        end
    end

    // Output registers driving the PIO.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            resultValid_q <= 1'b0;
            shortFrame_q  <= 1'b0;
        end else begin
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            resultValid_q <= resultValid_d;
            shortFrame_q  <= shortFrame_d;
        end
    end

    assign red_out      = red_q;
    assign green_out    = green_q;
    assign blue_out     = blue_q;
    assign result_valid = resultValid_q;
    assign short_frame  = shortFrame_q;

`ifdef CAMERA_RGB_SAMPLER_FRAMECNT_EN
    logic [15:0] frameCount_q, frameCount_d;

    // Frame counter steps with every result_valid or short_frame pulse.
    always_comb begin
        frameCount_d = frameCount_q;
        if (latchOut) begin
            frameCount_d = frameCount_q + 16'd1;
        end
    end

    // Frame counter register, wraps naturally at 16 bits.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frameCount_q <= '0;
        end else begin
            frameCount_q <= frameCount_d;
        end
    end

    assign frame_count = frameCount_q;
`endif

endmodule
